// File: rtl/mem_pkg.sv
// Shared codes for the L1 cache initiator: funct3 sizes, response errors, FSM encoding.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RD   = 2'b01;
  localparam logic [1:0] S_WR   = 2'b10;
  localparam logic [1:0] S_RESP = 2'b11;

  localparam logic MEM_SEL_ROM = 1'b0;
  localparam logic MEM_SEL_RAM = 1'b1;

  // Illegal encoding outranks misalignment when both apply.
  function automatic logic [1:0] access_check(input logic wr, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic illegal, mis;
    illegal = wr ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    mis     = (f3[1:0] == 2'b01 && off[0]) || (f3 == F3_W && off != 2'b00);
    return illegal ? ERR_ILLEGAL : (mis ? ERR_MISALIGN : ERR_OK);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and cache-port signals of the memory access unit.
interface mem_access_unit_if;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_write_enable, mem_read_enable;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_cache_ready;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out, mem_cache_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out, mem_cache_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into a cache word.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [4:0]  bsh, hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {off_i, 3'b000};
  assign hsh = {off_i[1], 4'b0000};
  assign b   = 8'(word_i >> bsh);
  assign h   = 16'(word_i >> hsh);

  always_comb begin
    load_o  = word_i;
    store_o = wdata_i;
    case (funct3_i)
      F3_B:    load_o = {{24{b[7]}}, b};
      F3_BU:   load_o = {24'b0, b};
      F3_H:    load_o = {{16{h[15]}}, h};
      F3_HU:   load_o = {16'b0, h};
      default: load_o = word_i;
    endcase
    case (funct3_i)
      F3_B:    store_o = (word_i & ~(32'h0000_00FF << bsh)) | ({24'b0, wdata_i[7:0]} << bsh);
      F3_H:    store_o = (word_i & ~(32'h0000_FFFF << hsh)) | ({16'b0, wdata_i[15:0]} << hsh);
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// L1 cache initiator: one load/store at a time, RMW for sub-word stores, bounded wait on cache_ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset_n,
  mem_access_unit_if.master bus
);

  logic [1:0]  st_q, st_d, err_q, err_d, chk;
  logic [2:0]  f3_q, f3_d;
  logic        wr_q, wr_d, timeout;
  logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [31:0] ld_data, st_word;

  mem_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .word_i   (bus.mem_data_out),
    .wdata_i  (data_q),
    .load_o   (ld_data),
    .store_o  (st_word)
  );

  assign chk     = access_check(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q + 32'd1 == TIMEOUT_CYCLES);

  always_comb begin
    st_d    = st_q;
    err_d   = err_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (st_q)
      S_IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        wr_d    = bus.req_write;
        f3_d    = bus.req_funct3;
        data_d  = bus.req_wdata;
        rdata_d = '0;
        err_d   = chk;
        cnt_d   = '0;
        if (chk != ERR_OK)                             st_d = S_RESP;
        else if (bus.req_write && bus.req_funct3 == F3_W) st_d = S_WR;
        else                                           st_d = S_RD;
      end
      S_RD: if (bus.mem_cache_ready) begin
        cnt_d = '0;
        // data_q switches from raw store data to the merged word here
        if (wr_q) begin data_d = st_word; st_d = S_WR; end
        else      begin rdata_d = ld_data; st_d = S_RESP; end
      end else if (timeout) begin
        err_d = ERR_TIMEOUT;
        st_d  = S_RESP;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      S_WR: if (bus.mem_cache_ready) begin
        st_d = S_RESP;
      end else if (timeout) begin
        err_d = ERR_TIMEOUT;
        st_d  = S_RESP;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= S_IDLE;
      err_q   <= ERR_OK;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready        = (st_q == S_IDLE);
  assign bus.resp_valid       = (st_q == S_RESP);
  assign bus.resp_rdata       = (st_q == S_RESP) ? rdata_q : '0;
  assign bus.resp_err         = (st_q == S_RESP) ? err_q : ERR_OK;
  assign bus.mem_read_enable  = (st_q == S_RD);
  assign bus.mem_write_enable = (st_q == S_WR);
  assign bus.mem_address      = {addr_q[31:2], 2'b00};
  assign bus.mem_data_in      = (st_q == S_WR) ? data_q : '0;

endmodule
